// File: rtl/mem_io_responder.sv
// mem_io_responder: memory-mapped responder for a small processor.
// Decodes ADDR[15:12] into a RAM, an LED register, a synchronized switch
// port and a free-running 16-bit timer, and returns registered read data.
//
// Ports:
//   Clock  - single clock; all state updates on its rising edge
//   Reset  - synchronous, active-high reset
//   ADDR   - word address from the processor
//   DOUT   - write data from the processor
//   W      - write strobe, valid for the single cycle the write applies
//   DIN    - registered read data (one-cycle latency from ADDR)
//   SW     - asynchronous slide switches
//   LEDR   - LED register outputs
module mem_io_responder #(
  parameter int unsigned AW = 8
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] ADDR,
  input  logic [15:0] DOUT,
  input  logic        W,
  output logic [15:0] DIN,
  input  logic [9:0]  SW,
  output logic [9:0]  LEDR
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned DW    = 16;
  localparam int unsigned SWW   = 10;

  localparam logic [3:0] SEL_RAM = 4'h0;
  localparam logic [3:0] SEL_LED = 4'h1;
  localparam logic [3:0] SEL_SW  = 4'h3;
  localparam logic [3:0] SEL_TMR = 4'h4;

  logic [3:0]    sel;
  logic [AW-1:0] ram_idx;
  logic          tmr_ctl;

  assign sel     = ADDR[15:12];
  assign ram_idx = ADDR[AW-1:0];
  assign tmr_ctl = ADDR[0];

  // Address bits outside the decode fields are intentionally ignored
  logic unused_addr;
  assign unused_addr = ^ADDR[11:0];

  // Write enables; at most one target per cycle, all suppressed by reset
  logic ram_we;
  logic led_we;
  logic tcnt_we;
  logic tctl_we;

  always_comb begin
    ram_we  = 1'b0;
    led_we  = 1'b0;
    tcnt_we = 1'b0;
    tctl_we = 1'b0;
    if (W && !Reset) begin
      case (sel)
        SEL_RAM: ram_we  = 1'b1;
        SEL_LED: led_we  = 1'b1;
        SEL_TMR: begin
          tcnt_we = !tmr_ctl;
          tctl_we = tmr_ctl;
        end
        default: ;
      endcase
    end
  end

  // RAM storage; contents survive reset
  logic [DW-1:0] ram [DEPTH];

  always_ff @(posedge Clock) begin
    if (ram_we) ram[ram_idx] <= DOUT;
  end

  // LED register
  always_ff @(posedge Clock) begin
    if (Reset)       LEDR <= '0;
    else if (led_we) LEDR <= DOUT[SWW-1:0];
  end

  // Two-flop switch synchronizer
  logic [SWW-1:0] sw_meta;
  logic [SWW-1:0] sw_sync;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= SW;
      sw_sync <= sw_meta;
    end
  end

  // Timer: a load from the bus wins over the increment in the same cycle
  logic [DW-1:0] tcnt;
  logic          tmr_en;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      tcnt   <= '0;
      tmr_en <= 1'b0;
    end else begin
      if (tcnt_we)     tcnt <= DOUT;
      else if (tmr_en) tcnt <= tcnt + DW'(1);
      if (tctl_we)     tmr_en <= DOUT[0];
    end
  end

  // Read mux; every source is sampled before the edge updates it, which
  // gives read-old-data for RAM and the pre-increment value for TCNT
  logic [DW-1:0] rd_data_c;

  always_comb begin
    rd_data_c = '0;
    case (sel)
      SEL_RAM: rd_data_c = ram[ram_idx];
      SEL_LED: rd_data_c = DW'(LEDR);
      SEL_SW:  rd_data_c = DW'(sw_sync);
      SEL_TMR: rd_data_c = tmr_ctl ? DW'(tmr_en) : tcnt;
      default: rd_data_c = '0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) DIN <= '0;
    else       DIN <= rd_data_c;
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: table-driven bench for mem_io_responder with a
// scoreboard queue of expected DIN/LEDR values per driven cycle.
module tb_mem_io_responder;

  logic        Clock;
  logic        Reset;
  logic [15:0] ADDR;
  logic [15:0] DOUT;
  logic        W;
  logic [15:0] DIN;
  logic [9:0]  SW;
  logic [9:0]  LEDR;

  mem_io_responder #(.AW(8)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .ADDR (ADDR),
    .DOUT (DOUT),
    .W    (W),
    .DIN  (DIN),
    .SW   (SW),
    .LEDR (LEDR)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] dout;
    logic        w;
    logic        rst;
    logic [15:0] din;
    logic        chk;
    logic [9:0]  led;
  } vec_t;

  typedef struct {
    logic [15:0] din;
    logic        chk;
    logic [9:0]  led;
    int          idx;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic add(input logic [15:0] a, input logic [15:0] d, input logic w,
                     input logic r, input logic [15:0] din, input logic chk,
                     input logic [9:0] led);
    vec_t v;
    v.addr = a; v.dout = d; v.w = w; v.rst = r;
    v.din = din; v.chk = chk; v.led = led;
    vecs.push_back(v);
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, req);
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] d, input logic w, input logic r);
    @(negedge Clock);
    ADDR = a; DOUT = d; W = w; Reset = r;
  endtask

  initial begin
    Reset = 1'b1; ADDR = '0; DOUT = '0; W = 1'b0; SW = 10'h155;

    //   addr     dout     w     rst   din      chk   led
    add(16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 10'h000); // 0 reset
    add(16'h1000, 16'h03FF, 1'b1, 1'b1, 16'h0000, 1'b1, 10'h000); // 1 write in reset dropped
    add(16'h4000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 10'h000); // 2 TCNT after reset
    add(16'h4001, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 10'h000); // 3 TCTL after reset
    add(16'h0005, 16'hBEEF, 1'b1, 1'b0, 16'h0000, 1'b0, 10'h000); // 4 RAM write
    add(16'h0005, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 1'b1, 10'h000); // 5 RAM read
    add(16'h0105, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 1'b1, 10'h000); // 6 alias
    add(16'h0003, 16'h1111, 1'b1, 1'b0, 16'h0000, 1'b0, 10'h000); // 7
    add(16'h0003, 16'h2222, 1'b1, 1'b0, 16'h1111, 1'b1, 10'h000); // 8 read-during-write old
    add(16'h0003, 16'h0000, 1'b0, 1'b0, 16'h2222, 1'b1, 10'h000); // 9 new word
    add(16'h1000, 16'h03FF, 1'b1, 1'b0, 16'h0000, 1'b1, 10'h3FF); // 10 LED write
    add(16'h1000, 16'h0000, 1'b0, 1'b0, 16'h03FF, 1'b1, 10'h3FF); // 11 LED read
    add(16'h3000, 16'h0000, 1'b0, 1'b0, 16'h0155, 1'b1, 10'h3FF); // 12 switch read
    add(16'h3000, 16'hFFFF, 1'b1, 1'b0, 16'h0155, 1'b1, 10'h3FF); // 13 switch write ignored
    add(16'h3000, 16'h0000, 1'b0, 1'b0, 16'h0155, 1'b1, 10'h3FF); // 14
    add(16'h4000, 16'hFFFE, 1'b1, 1'b0, 16'h0000, 1'b1, 10'h3FF); // 15 load TCNT
    add(16'h4001, 16'h0001, 1'b1, 1'b0, 16'h0000, 1'b1, 10'h3FF); // 16 EN=1
    add(16'h4000, 16'h0000, 1'b0, 1'b0, 16'hFFFE, 1'b1, 10'h3FF); // 17
    add(16'h4000, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 1'b1, 10'h3FF); // 18
    add(16'h4000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 10'h3FF); // 19 wrap
    add(16'h4000, 16'h0000, 1'b0, 1'b0, 16'h0001, 1'b1, 10'h3FF); // 20
    add(16'h4001, 16'h0000, 1'b0, 1'b0, 16'h0001, 1'b1, 10'h3FF); // 21 TCTL read
    add(16'h4000, 16'h0100, 1'b1, 1'b0, 16'h0003, 1'b1, 10'h3FF); // 22 load while counting
    add(16'h4000, 16'h0000, 1'b0, 1'b0, 16'h0100, 1'b1, 10'h3FF); // 23 load beats increment
    add(16'h4000, 16'h0000, 1'b0, 1'b0, 16'h0101, 1'b1, 10'h3FF); // 24
    add(16'h4001, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b1, 10'h3FF); // 25 EN=0
    add(16'h4000, 16'h0000, 1'b0, 1'b0, 16'h0103, 1'b1, 10'h3FF); // 26
    add(16'h4000, 16'h0000, 1'b0, 1'b0, 16'h0103, 1'b1, 10'h3FF); // 27 frozen
    add(16'h7000, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1, 10'h3FF); // 28 unmapped write
    add(16'h7000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 10'h3FF); // 29 unmapped read
    add(16'h1000, 16'h02AA, 1'b1, 1'b0, 16'h03FF, 1'b1, 10'h2AA); // 30
    add(16'h4001, 16'h0001, 1'b1, 1'b0, 16'h0000, 1'b1, 10'h2AA); // 31 EN=1
    add(16'h4000, 16'h0000, 1'b0, 1'b0, 16'h0103, 1'b1, 10'h2AA); // 32 counting
    add(16'h4000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 10'h000); // 33 reset mid-count
    add(16'h4000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 10'h000); // 34
    add(16'h4000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 10'h000); // 35 held at 0
    add(16'h4001, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 10'h000); // 36 EN cleared
    add(16'h0005, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 1'b1, 10'h000); // 37 RAM kept
    add(16'h0003, 16'h0000, 1'b0, 1'b0, 16'h2222, 1'b1, 10'h000); // 38 RAM kept
    add(16'h7000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 10'h000); // 39
    add(16'h2000, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 1'b1, 10'h000); // 40 unmapped write
    add(16'h1000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 10'h000); // 41 LED untouched
    add(16'h4000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 10'h000); // 42 TCNT untouched

    for (int i = 0; i < vecs.size(); i++) begin
      exp_t e;
      exp_t got;
      drive(vecs[i].addr, vecs[i].dout, vecs[i].w, vecs[i].rst);
      e.din = vecs[i].din; e.chk = vecs[i].chk; e.led = vecs[i].led; e.idx = i;
      exp_q.push_back(e);
      @(posedge Clock);
      #1;
      got = exp_q.pop_front();
      if (got.chk) check16($sformatf("din[%0d]", got.idx), DIN, got.din);
      check16($sformatf("ledr[%0d]", got.idx), 16'(LEDR), 16'(got.led));
    end

    // Switch change: new value appears on the third read through the synchronizer
    drive(16'h3000, 16'h0000, 1'b0, 1'b0);
    SW = 10'h2AA;
    @(posedge Clock); #1;
    check16("sw_lat1", DIN, 16'h0155);
    @(posedge Clock); #1;
    check16("sw_lat2", DIN, 16'h0155);
    @(posedge Clock); #1;
    check16("sw_lat3", DIN, 16'h02AA);

    // Back-to-back RAM writes to different words, then read both
    drive(16'h0010, 16'hA5A5, 1'b1, 1'b0);
    drive(16'h0011, 16'h5A5A, 1'b1, 1'b0);
    drive(16'h0010, 16'h0000, 1'b0, 1'b0);
    @(posedge Clock); #1;
    check16("ram_b2b0", DIN, 16'hA5A5);
    drive(16'h0F11, 16'h0000, 1'b0, 1'b0);
    @(posedge Clock); #1;
    check16("ram_b2b1", DIN, 16'h5A5A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
